// File: rtl/vospi_pkg.sv
// Shared types and VoSPI packet-ID field constants for the stream controller.
package vospi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESYNC = 2'd1,
        ST_ARM    = 2'd2,
        ST_WAIT   = 2'd3
    } vospi_state_e;

    localparam logic [3:0] VOSPI_DISCARD_NIBBLE = 4'hF;

    localparam int PKT_NUM_MSB = 11;
    localparam int PKT_NUM_LSB = 0;
    localparam int DISCARD_MSB = 11;
    localparam int DISCARD_LSB = 8;

endpackage

// File: rtl/vospi_timeout_counter.sv
// Cycle counter with synchronous clear; tc_o flags the last of limit_p counted cycles.
module vospi_timeout_counter #(
    parameter int limit_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int CW = (limit_p > 1) ? $clog2(limit_p) : 1;

    logic [CW-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !tc_o) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o = (count_q == CW'(limit_p - 1));

endmodule

// File: rtl/vospi_stream_ctrl.sv
// VoSPI stream sequencer: drives chip-select and packet starts, classifies finished
// packets, tracks the expected line number and forces a CS-high resync on errors.
module vospi_stream_ctrl
    import vospi_pkg::*;
#(
    parameter int id_width_p         = 16,
    parameter int lines_p            = 60,
    parameter int resync_cycles_p    = 16,
    parameter int pkt_timeout_p      = 4096,
    parameter int resync_cnt_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          enable_i,
    output logic                          cs_n_o,
    output logic                          start_o,
    input  logic                          packet_done_i,
    input  logic [id_width_p-1:0]         id_i,
    input  logic                          crc_ok_i,
    output logic                          line_valid_o,
    output logic [$clog2(lines_p)-1:0]    line_num_o,
    output logic                          frame_done_o,
    output logic [resync_cnt_width_p-1:0] resync_count_o,
    output logic                          busy_o
);

    localparam int LW = $clog2(lines_p);

    vospi_state_e state_q, state_d;
    logic [LW-1:0] exp_line_q;
    logic          resync_tc, timeout_tc;
    logic          pkt_accept, pkt_error, timeout_evt;
    logic          is_discard, line_match, last_line;
    logic [PKT_NUM_MSB:PKT_NUM_LSB] pkt_num;
    logic          unused_id_hi;

    assign pkt_num      = id_i[PKT_NUM_MSB:PKT_NUM_LSB];
    assign unused_id_hi = ^id_i[id_width_p-1:PKT_NUM_MSB+1];
    assign is_discard   = (id_i[DISCARD_MSB:DISCARD_LSB] == VOSPI_DISCARD_NIBBLE);
    // Range check first so out-of-range IDs cannot alias onto a valid line via the low bits.
    assign line_match   = (pkt_num < 12'(lines_p)) && (pkt_num[LW-1:0] == exp_line_q);
    assign last_line    = (exp_line_q == LW'(lines_p - 1));

    vospi_timeout_counter #(.limit_p(resync_cycles_p)) u_resync_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (state_q != ST_RESYNC),
        .enable_i  (state_q == ST_RESYNC),
        .tc_o      (resync_tc)
    );

    vospi_timeout_counter #(.limit_p(pkt_timeout_p)) u_pkt_timeout (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (state_q != ST_WAIT),
        .enable_i  (state_q == ST_WAIT),
        .tc_o      (timeout_tc)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pkt_accept  = 1'b0;
        pkt_error   = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_RESYNC;
            ST_RESYNC: begin
                if (!enable_i)      state_d = ST_IDLE;
                else if (resync_tc) state_d = ST_ARM;
            end
            ST_ARM:    state_d = enable_i ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (packet_done_i) begin
                    if (is_discard) begin
                        state_d = enable_i ? ST_ARM : ST_IDLE;
                    end else if (!crc_ok_i || !line_match) begin
                        pkt_error = 1'b1;
                        state_d   = enable_i ? ST_RESYNC : ST_IDLE;
                    end else begin
                        pkt_accept = 1'b1;
                        state_d    = enable_i ? ST_ARM : ST_IDLE;
                    end
                end else if (timeout_tc) begin
                    timeout_evt = 1'b1;
                    state_d     = enable_i ? ST_RESYNC : ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            exp_line_q     <= '0;
            line_valid_o   <= 1'b0;
            frame_done_o   <= 1'b0;
            line_num_o     <= '0;
            resync_count_o <= '0;
        end else begin
            state_q      <= state_d;
            line_valid_o <= pkt_accept;
            frame_done_o <= pkt_accept && last_line;
            if (state_q == ST_RESYNC) begin
                exp_line_q <= '0;
            end else if (pkt_accept) begin
                exp_line_q <= last_line ? '0 : exp_line_q + 1'b1;
            end
            if (pkt_accept) line_num_o <= pkt_num[LW-1:0];
            if ((pkt_error || timeout_evt) && (resync_count_o != '1)) begin
                resync_count_o <= resync_count_o + 1'b1;
            end
        end
    end

    assign cs_n_o  = (state_q == ST_IDLE) || (state_q == ST_RESYNC);
    assign start_o = (state_q == ST_ARM) && enable_i;
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vospi_stream_ctrl.sv
// Directed bench for vospi_stream_ctrl: accepted lines go through a queue-based scoreboard.
module tb_vospi_stream_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        cs_n_o, start_o;
    logic        packet_done_i = 1'b0;
    logic [15:0] id_i = '0;
    logic        crc_ok_i = 1'b0;
    logic        line_valid_o;
    logic [5:0]  line_num_o;
    logic        frame_done_o;
    logic [7:0]  resync_count_o;
    logic        busy_o;

    typedef enum int {K_ACCEPT, K_DISCARD, K_ERROR} kind_e;
    typedef struct {
        int line;
        int frame;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    vospi_stream_ctrl dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .enable_i       (enable_i),
        .cs_n_o         (cs_n_o),
        .start_o        (start_o),
        .packet_done_i  (packet_done_i),
        .id_i           (id_i),
        .crc_ok_i       (crc_ok_i),
        .line_valid_o   (line_valid_o),
        .line_num_o     (line_num_o),
        .frame_done_o   (frame_done_o),
        .resync_count_o (resync_count_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every line strobe must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (line_valid_o) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_line: got line %0d, expected no strobe", line_num_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("line_num", int'(line_num_o), e.line);
                check("frame_done", int'(frame_done_o), e.frame);
            end
        end else if (frame_done_o) begin
            check("frame_without_line", int'(frame_done_o), 0);
        end
    end

    task automatic wait_start();
        int n = 0;
        while (!start_o && n < 10000) begin
            @(negedge clk_i);
            n++;
        end
        check("start_seen", int'(start_o), 1);
    endtask

    task automatic send(input logic [15:0] id, input logic crc, input int gap, input kind_e kind);
        exp_t e;
        wait_start();
        repeat (gap) @(negedge clk_i);
        if (kind == K_ACCEPT) begin
            e.line  = int'(id[5:0]);
            e.frame = (id == 16'd59) ? 1 : 0;
            sb.push_back(e);
        end
        packet_done_i = 1'b1;
        id_i          = id;
        crc_ok_i      = crc;
        @(negedge clk_i);
        packet_done_i = 1'b0;
        crc_ok_i      = 1'b0;
        if (kind == K_ERROR) check("resync_cs_high", int'(cs_n_o), 1);
        else                 check("turnaround_start", int'(start_o), 1);
    endtask

    task automatic restart();
        int n = 0;
        enable_i = 1'b0;
        #1;
        check("start_gated", int'(start_o), 0);
        while (busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_after_disable", int'(busy_o), 0);
        enable_i = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, int'(cs_n_o), 1);
        check({tag, "_start"}, int'(start_o), 0);
        check({tag, "_line_valid"}, int'(line_valid_o), 0);
        check({tag, "_frame_done"}, int'(frame_done_o), 0);
        check({tag, "_line_num"}, int'(line_num_o), 0);
        check({tag, "_resync_count"}, int'(resync_count_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // 1: CS held high for the resync period, then the first start.
        enable_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (start_o) break;
            if (cs_n_o) cnt++;
        end
        check("resync_hold_cycles", cnt, 16);
        check("arm_cs_low", int'(cs_n_o), 0);

        // 2: full frame plus wrap to line 0.
        for (int i = 0; i < 60; i++) send(16'(i), 1'b1, 2, K_ACCEPT);
        send(16'h0000, 1'b1, 1, K_ACCEPT);
        check("frame_resync_count", int'(resync_count_o), 0);

        // 3: discard packet in the middle of a line sequence.
        restart();
        send(16'h0000, 1'b1, 1, K_ACCEPT);
        send(16'h0001, 1'b1, 3, K_ACCEPT);
        send(16'h0F00, 1'b1, 1, K_DISCARD);
        send(16'h0002, 1'b1, 1, K_ACCEPT);
        check("discard_resync_count", int'(resync_count_o), 0);

        // 4: line mismatch, then CRC error.
        send(16'h0005, 1'b1, 1, K_ERROR);
        check("mismatch_resync_count", int'(resync_count_o), 1);
        send(16'h0000, 1'b1, 1, K_ACCEPT);
        send(16'h0001, 1'b0, 1, K_ERROR);
        check("crc_resync_count", int'(resync_count_o), 2);

        // 5: packet timeout, then completion on the terminal cycle.
        wait_start();
        repeat (4096) @(negedge clk_i);
        check("timeout_not_early", int'(cs_n_o), 0);
        @(negedge clk_i);
        check("timeout_cs_high", int'(cs_n_o), 1);
        check("timeout_resync_count", int'(resync_count_o), 3);
        send(16'h0000, 1'b1, 4096, K_ACCEPT);
        check("terminal_done_count", int'(resync_count_o), 3);

        // 6: saturate the resync counter, then reset in the middle of a packet.
        for (int i = 0; i < 252; i++) send(16'h0007, 1'b0, 1, K_ERROR);
        check("count_reaches_max", int'(resync_count_o), 255);
        send(16'h0007, 1'b0, 1, K_ERROR);
        check("count_saturates", int'(resync_count_o), 255);
        wait_start();
        repeat (3) @(negedge clk_i);
        check("mid_wait_cs_low", int'(cs_n_o), 0);
        reset_n_i = 1'b0;
        enable_i  = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("post_reset_busy", int'(busy_o), 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
